sha256_msg_padder: RTL and testbench

Upstream feeder for the simplified SHA-256 hash core. It reads a NUM_OF_WORDS-word message from word-addressed memory and applies standard SHA-256 padding (0x80000000 marker word, zero fill, 64-bit bit-length). It delivers the message to the core as a sequence of 512-bit blocks over a valid/ready handshake. This replaces the core's internal whole-message read buffer with a streaming one-block-at-a-time front end.

---
 rtl/sha256_msg_padder.sv | 213 +++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_padder
// Purpose  : Streaming SHA-256 message front end. Reads a NUM_OF_WORDS-word
//            message from word-addressed memory, applies SHA-256 padding
//            (0x80000000 marker, zero fill, 64-bit bit length) and presents
//            the result one 512-bit block at a time over valid/ready.
// Ports    : clk, reset (sync, active-high), start, message_addr
//            mem_clk, mem_we, mem_addr, mem_read_data  - memory read port
//            blk_data, blk_valid, blk_ready, blk_last, blk_index - block out
//            busy, done                                  - status
// Options  : SHA_PAD_PREFETCH_EN - adds a second 512-bit output buffer so the
//            next block is fetched while the current one waits for transfer.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_last,
  output logic [7:0]   blk_index,
  output logic         busy,
  output logic         done
);

  localparam int             N_FULL    = NUM_OF_WORDS / 16;
  localparam int             REM       = NUM_OF_WORDS % 16;
  localparam int             NUM_BLKS  = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [7:0]     LAST_BLK  = 8'(NUM_BLKS - 1);
  localparam logic [7:0]     MARK_BLK  = 8'(N_FULL);
  localparam logic [63:0]    BIT_LEN   = 64'(NUM_OF_WORDS) * 64'd32;
  localparam logic [511:0]   MARK_VEC  = 512'h8000_0000 << (32 * REM);
  localparam logic [511:0]   LEN_VEC   = {BIT_LEN[31:0], BIT_LEN[63:32], 448'd0};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Number of message words carried by a given block.
  function automatic logic [4:0] words_in(input logic [7:0] blk);
    if (int'(blk) < N_FULL)       words_in = 5'd16;
    else if (int'(blk) == N_FULL) words_in = 5'(REM);
    else                          words_in = 5'd0;
  endfunction

  logic [1:0]   state, next_state;
  logic [7:0]   fblk;        // block currently being fetched
  logic [15:0]  base;
  logic [4:0]   issue_cnt;
  logic [3:0]   cap_cnt;
  logic         p1, p2;      // read in flight: address stage / data stage
  logic [511:0] fill;

  logic         accept, fetch_done, fblk_last, hand, xfer, launch, launch_next;
  logic [4:0]   cur_w, lw;
  logic [7:0]   lblk;
  logic [15:0]  lbase;
  logic [511:0] padded;

`ifdef SHA_PAD_PREFETCH_EN
  logic         out_valid, out_last;
  logic [511:0] out_buf;
  logic [7:0]   out_idx;
`endif

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  assign cur_w      = words_in(fblk);
  assign fblk_last  = (fblk == LAST_BLK);
  assign accept     = (state == S_IDLE) && start && !busy;
  // Data for the last issued word is on the bus while p2 is set.
  assign fetch_done = (state == S_FETCH) &&
                      ((cur_w == 5'd0) || (p2 && ({1'b0, cap_cnt} == cur_w - 5'd1)));
  assign padded     = fill | ((fblk == MARK_BLK) ? MARK_VEC : '0) |
                      (fblk_last ? LEN_VEC : '0);
  assign launch     = accept || launch_next;
  assign lblk       = accept ? 8'd0 : fblk + 8'd1;
  assign lbase      = accept ? message_addr : base;
  assign lw         = words_in(lblk);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_FETCH;
      S_FETCH: if (fetch_done) next_state = S_PAD;
`ifdef SHA_PAD_PREFETCH_EN
      S_PAD:   next_state = hand ? (fblk_last ? S_IDLE : S_FETCH) : S_HOLD;
`else
      S_PAD:   next_state = S_HOLD;
`endif
      S_HOLD:  if (hand) next_state = fblk_last ? S_IDLE : S_FETCH;
      default: next_state = S_IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
`ifdef SHA_PAD_PREFETCH_EN
    // The completed fill buffer moves to the output buffer whenever that
    // buffer is empty or being emptied in the same cycle.
    xfer      = out_valid && blk_ready;
    hand      = ((state == S_PAD) || (state == S_HOLD)) && (!out_valid || blk_ready);
    blk_valid = out_valid;
    blk_data  = out_buf;
    blk_last  = out_last;
    blk_index = out_idx;
`else
    hand      = (state == S_HOLD) && blk_ready;
    xfer      = hand;
    blk_valid = (state == S_HOLD);
    blk_data  = fill;
    blk_last  = (state == S_HOLD) && fblk_last;
    blk_index = fblk;
`endif
    launch_next = hand && !fblk_last;
  end

  // Fetch datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      fblk      <= 8'd0;
      base      <= 16'd0;
      issue_cnt <= 5'd0;
      cap_cnt   <= 4'd0;
      p1        <= 1'b0;
      p2        <= 1'b0;
      mem_addr  <= 16'd0;
      fill      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      p2   <= p1;
      done <= xfer && blk_last;
      if (accept) begin
        busy <= 1'b1;
        base <= message_addr;
      end else if (xfer && blk_last) begin
        busy <= 1'b0;
      end

      // A launch issues the first read of the new block on the same edge.
      if (launch) begin
        fblk    <= lblk;
        cap_cnt <= 4'd0;
        if (lw != 5'd0) begin
          mem_addr  <= lbase + {4'd0, lblk, 4'd0};
          issue_cnt <= 5'd1;
          p1        <= 1'b1;
        end else begin
          mem_addr  <= 16'd0;
          issue_cnt <= 5'd0;
          p1        <= 1'b0;
        end
      end else if ((state == S_FETCH) && (issue_cnt < cur_w)) begin
        mem_addr  <= base + {4'd0, fblk, 4'd0} + {11'd0, issue_cnt};
        issue_cnt <= issue_cnt + 5'd1;
        p1        <= 1'b1;
      end else begin
        mem_addr <= 16'd0;
        p1       <= 1'b0;
      end

      if (launch) begin
        fill <= '0;
      end else if (state == S_PAD) begin
        fill <= padded;
      end else if ((state == S_FETCH) && p2) begin
        fill[{cap_cnt, 5'd0} +: 32] <= mem_read_data;
        cap_cnt <= cap_cnt + 4'd1;
      end
    end
  end

`ifdef SHA_PAD_PREFETCH_EN
  // Output buffer; contents frozen while out_valid is high and not taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= 8'd0;
      out_buf   <= '0;
    end else if (hand) begin
      out_valid <= 1'b1;
      out_last  <= fblk_last;
      out_idx   <= fblk;
      out_buf   <= (state == S_PAD) ? padded : fill;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_padder
// Purpose  : Self-checking bench for sha256_msg_padder. Three instances
//            (N = 20, 14, 16) share one synchronous-read memory. Expected
//            blocks come from a padded word queue built from the message.
//            Honours SHA_PAD_PREFETCH_EN for the inter-block gap check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_s [3];
  logic [15:0]  addr_s  [3];
  logic         mclk_s  [3];
  logic         mwe_s   [3];
  logic [15:0]  maddr_s [3];
  logic [31:0]  rdata_s [3];
  logic [511:0] bd_s    [3];
  logic         bv_s    [3];
  logic         br_s    [3];
  logic         bl_s    [3];
  logic [7:0]   bi_s    [3];
  logic         busy_s  [3];
  logic         done_s  [3];

  logic [31:0]  mem [65536];

  int tests = 0;
  int fails = 0;

  function automatic int nw_of(input int d);
    return (d == 0) ? 20 : (d == 1) ? 14 : 16;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256_msg_padder #(.NUM_OF_WORDS((g == 0) ? 20 : (g == 1) ? 14 : 16)) dut (
      .clk(clk), .reset(reset), .start(start_s[g]), .message_addr(addr_s[g]),
      .mem_clk(mclk_s[g]), .mem_we(mwe_s[g]), .mem_addr(maddr_s[g]),
      .mem_read_data(rdata_s[g]), .blk_data(bd_s[g]), .blk_valid(bv_s[g]),
      .blk_ready(br_s[g]), .blk_last(bl_s[g]), .blk_index(bi_s[g]),
      .busy(busy_s[g]), .done(done_s[g])
    );
  end

  // Memory: data valid the cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdata_s[i] <= mem[maddr_s[i]];
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one message on instance d. mode 0: word k = k+1, else random.
  // stall_blk: block index held off with blk_ready low for 10 cycles (-1 none).
  task automatic run_msg(input int d, input logic [15:0] base, input int mode, input int stall_blk);
    int n, nb, cyc, w;
    logic [31:0] q[$];
    logic [511:0] exp, hold_d;
    logic [7:0] hold_i;
    bit stable;
    logic [15:0] a;
    n = nw_of(d);
    for (int k = 0; k < n; k++) begin
      a = base + 16'(k);
      mem[a] = (mode == 0) ? 32'(k + 1) : $urandom;
      q.push_back(mem[a]);
    end
    q.push_back(32'h8000_0000);
    while ((q.size() % 16) != 14) q.push_back(32'h0);
    q.push_back(32'h0);
    q.push_back(32'(n * 32));
    nb = q.size() / 16;

    chk("done_idle", done_s[d], 0);
    br_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b1;
    addr_s[d]  = base;
    @(posedge clk);
    @(negedge clk);
    start_s[d] = 1'b0;
    chk("busy_after_start", busy_s[d], 1);

    for (int b = 0; b < nb; b++) begin
      w = n - 16 * b;
      if (w > 16) w = 16;
      if (w < 0)  w = 0;
      if (b == stall_blk) br_s[d] = 1'b0;
      cyc = 0;
      while (!bv_s[d] && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 200) begin
        chk("valid_timeout", 0, 1);
        return;
      end
`ifdef SHA_PAD_PREFETCH_EN
      if (b == 0) chk("first_latency", cyc, w + 2);
      else        chk("gap_le", (cyc <= w + 2), 1);
`else
      chk("latency", cyc, w + 2);
`endif
      exp = '0;
      for (int j = 0; j < 16; j++) exp[j * 32 +: 32] = q[16 * b + j];
      chk("blk_data", bd_s[d], exp);
      chk("blk_index", bi_s[d], b);
      chk("blk_last", bl_s[d], (b == nb - 1));
      if (b == stall_blk) begin
        hold_d = bd_s[d];
        hold_i = bi_s[d];
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (bd_s[d] !== hold_d || bi_s[d] !== hold_i || bv_s[d] !== 1'b1) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        br_s[d] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (b == nb - 1) begin
        chk("done_pulse", done_s[d], 1);
        chk("busy_fall", busy_s[d], 0);
        @(negedge clk);
        chk("done_single", done_s[d], 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      addr_s[i]  = 16'h0;
      br_s[i]    = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", bv_s[i], 0);
      chk("rst_last", bl_s[i], 0);
      chk("rst_index", bi_s[i], 0);
      chk("rst_busy", busy_s[i], 0);
      chk("rst_done", done_s[i], 0);
      chk("rst_mem_addr", maddr_s[i], 0);
      chk("rst_data", bd_s[i], 0);
      chk("mem_we", mwe_s[i], 0);
    end
    reset = 1'b0;

    // Directed plan cases
    run_msg(0, 16'h1000, 0, -1);
    run_msg(1, 16'(($urandom % 60000)), 1, -1);
    run_msg(2, 16'(($urandom % 60000)), 1, -1);

    // Backpressure
    run_msg(0, 16'h2345, 1, 0);
    run_msg(1, 16'h0100, 1, 1);

    // Reset while fetching block 0, then a fresh message
    @(negedge clk);
    start_s[0] = 1'b1;
    addr_s[0]  = 16'h3000;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy_s[0], 0);
    chk("abort_valid", bv_s[0], 0);
    chk("abort_done", done_s[0], 0);
    reset = 1'b0;
    run_msg(0, 16'h3000, 1, -1);

    // Address wrap-around
    run_msg(0, 16'hFFF8, 1, -1);
    run_msg(2, 16'hFFF5, 1, -1);

    // Random traffic
    for (int i = 0; i < 4; i++) begin
      run_msg(i % 3, 16'($urandom), 1, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
